// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the decode-side
// instruction handoff and branch feedback from the datapath.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [15:0] retired;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4, retired,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc, pc_plus4, retired,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, fetches over req/ack, holds the
// word for decode and advances sequentially or by a taken beq on consume.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {RST, REQ, HOLD} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] retired_q, retired_d;
  logic [31:0] pc_plus4;

  // Offset is in words; the word-aligned result keeps pc[1:0] at zero.
  function automatic logic [31:0] next_pc(input logic [31:0] seq_pc,
                                          input logic taken,
                                          input logic [31:0] offset);
    logic [31:0] tgt;
    tgt = taken ? seq_pc + {offset[29:0], 2'b00} : seq_pc;
    return {tgt[31:2], 2'b00};
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      RST: state_d = REQ;
      REQ: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d      = next_pc(pc_plus4, bus.branch_taken, bus.branch_offset);
          retired_d = retired_q + 16'd1;
          state_d   = REQ;
        end
      end
      default: state_d = RST;
    endcase
  end

  // Every output is decoded from registers only, so decode sees a stable opcode.
  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, zero-wait fetch, stalls,
// branches, PC wrap and reset during an outstanding request.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  instr_fetch_if bus();
  instr_fetch_if bus_hi();
  instr_fetch_if bus_w();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut      (.clk(clk), .rst_n(rst_n), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'h0040_0000)) u_dut_hi   (.clk(clk), .rst_n(rst_n), .bus(bus_hi));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic do_consume(input logic taken, input logic [31:0] off);
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = taken;
    bus.branch_offset = off;
    tick();
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 32'h0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req cyc=%0d act=%b req=0", i, bus.imem_req); end
      n_chk++; if (bus_hi.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_hi cyc=%0d act=%b req=0", i, bus_hi.imem_req); end
    end
    n_chk++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc act=%h req=0", bus.pc); end
    n_chk++; if (bus.pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc_plus4 act=%h req=4", bus.pc_plus4); end
    n_chk++; if (bus.instr !== 32'h0 || bus.opcode !== 6'h0) begin n_fail++; $display("FAIL rst_instr act=%h/%h req=0/0", bus.instr, bus.opcode); end
    n_chk++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid act=%b req=0", bus.instr_valid); end
    n_chk++; if (bus.retired !== 16'h0) begin n_fail++; $display("FAIL rst_retired act=%h req=0", bus.retired); end
    n_chk++; if (bus_hi.imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL rst_addr_hi act=%h req=00400000", bus_hi.imem_addr); end
    n_chk++; if (bus_hi.pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL rst_pc_plus4_hi act=%h req=00400004", bus_hi.pc_plus4); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus_hi.imem_req !== 1'b1 || bus_hi.imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL rel_req_hi act=%b/%h req=1/00400000", bus_hi.imem_req, bus_hi.imem_addr); end
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_req act=%b/%h req=1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_straight_line();
    logic [31:0] words [4];
    logic [5:0]  ops   [4];
    words = '{32'h8C08_0004, 32'hAC09_0008, 32'h0109_5020, 32'h1000_FFFF};
    ops   = '{6'h23, 6'h2B, 6'h00, 6'h04};
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr i=%0d act=%b/%h req=1/%h", i, bus.imem_req, bus.imem_addr, 32'(i * 4)); end
      bus.imem_ack   = bus.imem_req;
      bus.imem_rdata = words[i];
      tick();
      bus.imem_ack   = bus.imem_req;
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.opcode !== ops[i]) begin n_fail++; $display("FAIL seq_opcode i=%0d act=%b/%h req=1/%h", i, bus.instr_valid, bus.opcode, ops[i]); end
      tick();
    end
    bus.instr_ready = 1'b0;
    bus.imem_ack    = 1'b0;
    n_chk++; if (bus.retired !== 16'd4) begin n_fail++; $display("FAIL seq_retired act=%0d req=4", bus.retired); end
    n_chk++; if (bus.pc !== 32'h10 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_pc act=%h/%b req=10/0", bus.pc, bus.instr_valid); end
  endtask

  task automatic test_stalls();
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL wait_req cyc=%0d act=%b/%h req=1/10", i, bus.imem_req, bus.imem_addr); end
      bus.instr_ready = (i == 1);
      tick();
    end
    bus.instr_ready = 1'b0;
    n_chk++; if (bus.retired !== 16'd4 || bus.pc !== 32'h10) begin n_fail++; $display("FAIL ready_ignored act=%0d/%h req=4/10", bus.retired, bus.pc); end
    do_fetch(32'h2008_0001);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_ctl cyc=%0d act=%b/%b req=1/0", i, bus.instr_valid, bus.imem_req); end
      n_chk++; if (bus.instr !== 32'h2008_0001 || bus.pc !== 32'h10 || bus.retired !== 16'd4) begin n_fail++; $display("FAIL stall_hold cyc=%0d act=%h/%h/%0d req=20080001/10/4", i, bus.instr, bus.pc, bus.retired); end
      bus.imem_ack   = (i == 2);
      bus.imem_rdata = 32'hFFFF_FFFF;
      tick();
    end
    bus.imem_ack = 1'b0;
    n_chk++; if (bus.instr !== 32'h2008_0001) begin n_fail++; $display("FAIL ack_ignored act=%h req=20080001", bus.instr); end
    do_consume(1'b0, 32'h0);
    n_chk++; if (bus.pc !== 32'h14 || bus.retired !== 16'd5) begin n_fail++; $display("FAIL consume act=%h/%0d req=14/5", bus.pc, bus.retired); end
    n_chk++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h2008_0001) begin n_fail++; $display("FAIL after_consume act=%b/%b/%h req=1/0/20080001", bus.imem_req, bus.instr_valid, bus.instr); end
  endtask

  task automatic test_branches();
    for (int i = 0; i < 3; i++) begin
      do_fetch(32'h0);
      do_consume(1'b0, 32'h0);
    end
    n_chk++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL br_setup act=%h req=20", bus.pc); end
    do_fetch(32'h1000_FFFD);
    do_consume(1'b1, 32'hFFFF_FFFD);
    n_chk++; if (bus.pc !== 32'h18 || bus.imem_addr !== 32'h18) begin n_fail++; $display("FAIL br_backward act=%h/%h req=18", bus.pc, bus.imem_addr); end
    for (int i = 0; i < 2; i++) begin
      do_fetch(32'h0);
      do_consume(1'b0, 32'h0);
    end
    do_fetch(32'h1000_0002);
    do_consume(1'b1, 32'h0000_0002);
    n_chk++; if (bus.pc !== 32'h2C || bus.imem_addr !== 32'h2C) begin n_fail++; $display("FAIL br_forward act=%h/%h req=2C", bus.pc, bus.imem_addr); end
    do_fetch(32'h1000_FFFC);
    do_consume(1'b1, 32'hFFFF_FFFC);
    n_chk++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL br_back4 act=%h req=20", bus.pc); end
    do_fetch(32'h1000_0004);
    do_consume(1'b0, 32'h0000_0010);
    n_chk++; if (bus.pc !== 32'h24) begin n_fail++; $display("FAIL br_not_taken act=%h req=24", bus.pc); end
    n_chk++; if (bus.retired !== 16'd14) begin n_fail++; $display("FAIL br_retired act=%0d req=14", bus.retired); end
  endtask

  task automatic test_pc_wrap();
    n_chk++; if (bus_w.imem_addr !== 32'hFFFF_FFFC || bus_w.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_start act=%h/%h req=FFFFFFFC/0", bus_w.imem_addr, bus_w.pc_plus4); end
    bus_w.imem_ack   = 1'b1;
    bus_w.imem_rdata = 32'h8C00_0000;
    tick();
    bus_w.imem_ack   = 1'b0;
    n_chk++; if (bus_w.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid act=%b req=1", bus_w.instr_valid); end
    bus_w.instr_ready = 1'b1;
    tick();
    bus_w.instr_ready = 1'b0;
    n_chk++; if (bus_w.imem_addr !== 32'h0 || bus_w.imem_req !== 1'b1 || bus_w.retired !== 16'd1) begin n_fail++; $display("FAIL wrap_addr act=%h/%b/%0d req=0/1/1", bus_w.imem_addr, bus_w.imem_req, bus_w.retired); end
  endtask

  task automatic test_reset_mid_request();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin n_fail++; $display("FAIL mid_pre act=%b/%h req=1/24", bus.imem_req, bus.imem_addr); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async act=%b/%b req=0/0", bus.imem_req, bus.instr_valid); end
    n_chk++; if (bus.pc !== 32'h0 || bus.retired !== 16'h0) begin n_fail++; $display("FAIL mid_clear act=%h/%0d req=0/0", bus.pc, bus.retired); end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    n_chk++; if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_latch act=%h/%b req=0/0", bus.instr, bus.instr_valid); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr !== 32'h0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_refetch act=%b/%h/%h/%b req=1/0/0/0", bus.imem_req, bus.imem_addr, bus.instr, bus.instr_valid); end
    tick();
    bus.imem_ack = 1'b0;
    n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hDEAD_BEEF || bus.opcode !== 6'h37) begin n_fail++; $display("FAIL mid_fetch act=%b/%h/%h req=1/DEADBEEF/37", bus.instr_valid, bus.instr, bus.opcode); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.imem_ack = 1'b0;    bus.imem_rdata = 32'h0;    bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_offset = 32'h0;
    bus_hi.imem_ack = 1'b0; bus_hi.imem_rdata = 32'h0; bus_hi.instr_ready = 1'b0;
    bus_hi.branch_taken = 1'b0; bus_hi.branch_offset = 32'h0;
    bus_w.imem_ack = 1'b0;  bus_w.imem_rdata = 32'h0;  bus_w.instr_ready = 1'b0;
    bus_w.branch_taken = 1'b0; bus_w.branch_offset = 32'h0;

    test_reset();
    test_straight_line();
    test_stalls();
    test_branches();
    test_pc_wrap();
    test_reset_mid_request();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
